// File: rtl/exu_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-back arbiter:
// source IDs, port widths and the buffered write request type.
package exu_wb_arbiter_pkg;

    localparam int WB_SRC_MEM    = 0;
    localparam int WB_SRC_MULDIV = 1;
    localparam int WB_SRC_PIPE   = 2;
    localparam int WB_NSRC       = 3;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] waddr;
        logic [REG_DATA_W-1:0] wdata;
    } wb_req_t;

    // x0 is hardwired to zero, so a granted write to it is consumed silently
    function automatic logic wb_write_en(input logic grant, input logic [REG_ADDR_W-1:0] waddr);
        return grant & (waddr != {REG_ADDR_W{1'b0}});
    endfunction

endpackage

// File: rtl/exu_wb_arbiter_if.sv
// Handshake bundle between the completion sources, the arbiter and the regfile write port.
interface exu_wb_arbiter_if;

    logic                                     pipe_valid_i;
    logic                                     pipe_we_i;
    logic [exu_wb_arbiter_pkg::REG_ADDR_W-1:0] pipe_waddr_i;
    logic [exu_wb_arbiter_pkg::REG_DATA_W-1:0] pipe_wdata_i;
    logic                                     pipe_ready_o;

    logic                                     mem_valid_i;
    logic [exu_wb_arbiter_pkg::REG_ADDR_W-1:0] mem_waddr_i;
    logic [exu_wb_arbiter_pkg::REG_DATA_W-1:0] mem_wdata_i;
    logic                                     mem_ready_o;

    logic                                     muldiv_valid_i;
    logic [exu_wb_arbiter_pkg::REG_ADDR_W-1:0] muldiv_waddr_i;
    logic [exu_wb_arbiter_pkg::REG_DATA_W-1:0] muldiv_wdata_i;
    logic                                     muldiv_ready_o;

    logic                                     reg_we_o;
    logic [exu_wb_arbiter_pkg::REG_ADDR_W-1:0] reg_waddr_o;
    logic [exu_wb_arbiter_pkg::REG_DATA_W-1:0] reg_wdata_o;

    modport master (
        output pipe_valid_i, pipe_we_i, pipe_waddr_i, pipe_wdata_i,
        output mem_valid_i, mem_waddr_i, mem_wdata_i,
        output muldiv_valid_i, muldiv_waddr_i, muldiv_wdata_i,
        input  pipe_ready_o, mem_ready_o, muldiv_ready_o,
        input  reg_we_o, reg_waddr_o, reg_wdata_o
    );

    modport slave (
        input  pipe_valid_i, pipe_we_i, pipe_waddr_i, pipe_wdata_i,
        input  mem_valid_i, mem_waddr_i, mem_wdata_i,
        input  muldiv_valid_i, muldiv_waddr_i, muldiv_wdata_i,
        output pipe_ready_o, mem_ready_o, muldiv_ready_o,
        output reg_we_o, reg_waddr_o, reg_wdata_o
    );

endinterface

// File: rtl/exu_wb_arbiter_hold_buf.sv
// One-entry holding buffer for a variable-latency completion source; it can
// drain and refill in the same cycle, so a winning source streams at full rate.
module wb_hold_buf
    import exu_wb_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [REG_ADDR_W-1:0] waddr_i,
    input  logic [REG_DATA_W-1:0] wdata_i,
    output logic                  ready_o,
    input  logic                  gnt_i,
    output logic                  vld_o,
    output wb_req_t               req_o
);

    logic    vld_q, vld_d;
    wb_req_t req_q, req_d;
    logic    ready_s;

    // Accept when empty or when the held entry leaves this cycle
    always_comb begin
        ready_s = ~vld_q | gnt_i;
        vld_d   = vld_q;
        req_d   = req_q;
        if (valid_i && ready_s) begin
            vld_d       = 1'b1;
            req_d.waddr = waddr_i;
            req_d.wdata = wdata_i;
        end else if (gnt_i) begin
            vld_d = 1'b0;
        end else begin
            vld_d = vld_q;
        end
    end

    // Buffer state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            req_q <= '0;
        end else begin
            vld_q <= vld_d;
            req_q <= req_d;
        end
    end

    assign ready_o = ready_s;
    assign vld_o   = vld_q;
    assign req_o   = req_q;

endmodule

// File: rtl/exu_wb_arbiter.sv
// Register-file write-port arbiter: mem buffer > muldiv buffer > execute pipe,
// with a starvation override that lets a repeatedly denied pipe result through.
module exu_wb_arbiter
    import exu_wb_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    exu_wb_arbiter_if.slave  wb
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic                  mem_vld_s, muldiv_vld_s;
    wb_req_t               mem_req_s, muldiv_req_s;
    logic                  mem_ready_s, muldiv_ready_s;
    logic                  pipe_cand_s, override_s, grant_any_s;
    logic [WB_NSRC-1:0]    gnt_s;

    logic [3:0]            starve_q, starve_d;
    logic                  reg_we_q, reg_we_d;
    logic [REG_ADDR_W-1:0] reg_waddr_q, reg_waddr_d;
    logic [REG_DATA_W-1:0] reg_wdata_q, reg_wdata_d;

    wb_hold_buf u_mem_buf (
        .clk     (clk),
        .rst     (rst),
        .valid_i (wb.mem_valid_i),
        .waddr_i (wb.mem_waddr_i),
        .wdata_i (wb.mem_wdata_i),
        .ready_o (mem_ready_s),
        .gnt_i   (gnt_s[WB_SRC_MEM]),
        .vld_o   (mem_vld_s),
        .req_o   (mem_req_s)
    );

    wb_hold_buf u_muldiv_buf (
        .clk     (clk),
        .rst     (rst),
        .valid_i (wb.muldiv_valid_i),
        .waddr_i (wb.muldiv_waddr_i),
        .wdata_i (wb.muldiv_wdata_i),
        .ready_o (muldiv_ready_s),
        .gnt_i   (gnt_s[WB_SRC_MULDIV]),
        .vld_o   (muldiv_vld_s),
        .req_o   (muldiv_req_s)
    );

    // Fixed-priority select; the override pre-empts both buffers
    always_comb begin
        pipe_cand_s = wb.pipe_valid_i & wb.pipe_we_i;
        override_s  = pipe_cand_s & (starve_q == STARVE_LIM);
        gnt_s       = '0;
        if (override_s) begin
            gnt_s[WB_SRC_PIPE] = 1'b1;
        end else if (mem_vld_s) begin
            gnt_s[WB_SRC_MEM] = 1'b1;
        end else if (muldiv_vld_s) begin
            gnt_s[WB_SRC_MULDIV] = 1'b1;
        end else if (pipe_cand_s) begin
            gnt_s[WB_SRC_PIPE] = 1'b1;
        end else begin
            gnt_s = '0;
        end
        grant_any_s = |gnt_s;
    end

    // Starvation count and next write-port contents
    always_comb begin
        if (!pipe_cand_s || gnt_s[WB_SRC_PIPE]) begin
            starve_d = 4'd0;
        end else if (starve_q < STARVE_LIM) begin
            starve_d = starve_q + 4'd1;
        end else begin
            starve_d = starve_q;
        end

        reg_waddr_d = reg_waddr_q;
        reg_wdata_d = reg_wdata_q;
        if (gnt_s[WB_SRC_MEM]) begin
            reg_waddr_d = mem_req_s.waddr;
            reg_wdata_d = mem_req_s.wdata;
        end else if (gnt_s[WB_SRC_MULDIV]) begin
            reg_waddr_d = muldiv_req_s.waddr;
            reg_wdata_d = muldiv_req_s.wdata;
        end else if (gnt_s[WB_SRC_PIPE]) begin
            reg_waddr_d = wb.pipe_waddr_i;
            reg_wdata_d = wb.pipe_wdata_i;
        end else begin
            reg_waddr_d = reg_waddr_q;
            reg_wdata_d = reg_wdata_q;
        end
        reg_we_d = wb_write_en(grant_any_s, reg_waddr_d);
    end

    // Starvation counter and registered regfile write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q    <= 4'd0;
            reg_we_q    <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
        end else begin
            starve_q    <= starve_d;
            reg_we_q    <= reg_we_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
        end
    end

    assign wb.mem_ready_o    = mem_ready_s;
    assign wb.muldiv_ready_o = muldiv_ready_s;
    assign wb.pipe_ready_o   = ~wb.pipe_valid_i | ~wb.pipe_we_i | gnt_s[WB_SRC_PIPE];
    assign wb.reg_we_o       = reg_we_q;
    assign wb.reg_waddr_o    = reg_waddr_q;
    assign wb.reg_wdata_o    = reg_wdata_q;

endmodule

// File: tb/tb_exu_wb_arbiter.sv
// Directed and randomized bench for exu_wb_arbiter against a queue-based
// model of the write-back rules (priority, starvation limit, x0 suppression).
module tb_exu_wb_arbiter;
    import exu_wb_arbiter_pkg::*;

    localparam int SM = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exu_wb_arbiter_if wb_if ();

    exu_wb_arbiter #(.STARVE_MAX(SM)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb_if)
    );

    int total = 0;
    int bad   = 0;

    // model state
    wb_req_t     memq[$];
    wb_req_t     mdq[$];
    int          starve;
    logic        exp_we;
    logic [4:0]  exp_wa;
    logic [31:0] exp_wd;
    int          winlog[$];
    int          stall_cnt;
    bit          last_mem_acc;
    bit          last_pipe_gnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit pv, input bit pwe, input logic [4:0] pa, input logic [31:0] pd,
                         input bit mv, input logic [4:0] ma, input logic [31:0] md,
                         input bit dv, input logic [4:0] da, input logic [31:0] dd);
        wb_if.pipe_valid_i   = pv;
        wb_if.pipe_we_i      = pwe;
        wb_if.pipe_waddr_i   = pa;
        wb_if.pipe_wdata_i   = pd;
        wb_if.mem_valid_i    = mv;
        wb_if.mem_waddr_i    = ma;
        wb_if.mem_wdata_i    = md;
        wb_if.muldiv_valid_i = dv;
        wb_if.muldiv_waddr_i = da;
        wb_if.muldiv_wdata_i = dd;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic model_clear();
        memq.delete();
        mdq.delete();
        starve = 0;
        exp_we = 1'b0;
        exp_wa = 5'd0;
        exp_wd = 32'd0;
    endtask

    // One clock: check last write, apply inputs, check readies, advance the model
    task automatic step(input bit pv, input bit pwe, input logic [4:0] pa, input logic [31:0] pd,
                        input bit mv, input logic [4:0] ma, input logic [31:0] md,
                        input bit dv, input logic [4:0] da, input logic [31:0] dd);
        bit      pc;
        int      win;
        bit      m_rdy, d_rdy, p_rdy;
        wb_req_t w;
        @(negedge clk);
        check_eq("reg_we", wb_if.reg_we_o, exp_we);
        check_eq("reg_waddr", wb_if.reg_waddr_o, exp_wa);
        check_eq("reg_wdata", wb_if.reg_wdata_o, exp_wd);
        drive(pv, pwe, pa, pd, mv, ma, md, dv, da, dd);
        #1;
        pc  = pv && pwe;
        win = -1;
        if (pc && starve >= SM)  win = WB_SRC_PIPE;
        else if (memq.size() > 0) win = WB_SRC_MEM;
        else if (mdq.size() > 0)  win = WB_SRC_MULDIV;
        else if (pc)              win = WB_SRC_PIPE;
        m_rdy = (memq.size() == 0) || (win == WB_SRC_MEM);
        d_rdy = (mdq.size() == 0) || (win == WB_SRC_MULDIV);
        p_rdy = !pc || (win == WB_SRC_PIPE);
        check_eq("mem_ready", wb_if.mem_ready_o, m_rdy);
        check_eq("muldiv_ready", wb_if.muldiv_ready_o, d_rdy);
        check_eq("pipe_ready", wb_if.pipe_ready_o, p_rdy);
        if (!p_rdy) stall_cnt++;
        w.waddr = pa;
        w.wdata = pd;
        if (win == WB_SRC_MEM)    w = memq.pop_front();
        if (win == WB_SRC_MULDIV) w = mdq.pop_front();
        if (win >= 0) begin
            exp_wa = w.waddr;
            exp_wd = w.wdata;
            exp_we = (w.waddr != 5'd0);
        end else begin
            exp_we = 1'b0;
        end
        if (!pc || win == WB_SRC_PIPE) starve = 0;
        else if (starve < SM)          starve = starve + 1;
        if (mv && m_rdy) memq.push_back('{waddr: ma, wdata: md});
        if (dv && d_rdy) mdq.push_back('{waddr: da, wdata: dd});
        last_mem_acc  = mv && m_rdy;
        last_pipe_gnt = (win == WB_SRC_PIPE);
        winlog.push_back(win);
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // Asynchronous reset mid-cycle with every source asserting
    task automatic do_reset(input string tag);
        @(negedge clk);
        drive(1'b1, 1'b1, 5'd9, 32'hDEAD, 1'b1, 5'd10, 32'hBEEF, 1'b1, 5'd11, 32'hCAFE);
        #2;
        rst = 1'b1;
        #1;
        check_eq({tag, "_we"}, wb_if.reg_we_o, 1'b0);
        check_eq({tag, "_waddr"}, wb_if.reg_waddr_o, 5'd0);
        check_eq({tag, "_wdata"}, wb_if.reg_wdata_o, 32'd0);
        check_eq({tag, "_mem_rdy"}, wb_if.mem_ready_o, 1'b1);
        check_eq({tag, "_md_rdy"}, wb_if.muldiv_ready_o, 1'b1);
        check_eq({tag, "_pipe_rdy"}, wb_if.pipe_ready_o, 1'b1);
        @(negedge clk);
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        model_clear();
    endtask

    initial begin
        int mem_seq;
        int grant_at;
        rst = 1'b1;
        idle_inputs();
        model_clear();
        stall_cnt = 0;
        do_reset("rst0");

        // single pipe write
        step(1'b1, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        idle_step();
        check_eq("t1_waddr", wb_if.reg_waddr_o, 5'd5);

        // mem and pipe arrive together: pipe first, mem one cycle later
        step(1'b1, 1'b1, 5'd7, 32'hBB, 1'b1, 5'd3, 32'hAA, 1'b0, 5'd0, 32'd0);
        idle_step();
        idle_step();
        check_eq("t2_mem_wdata", wb_if.reg_wdata_o, 32'hAA);
        idle_step();

        // both buffers full, pipe held: mem, muldiv, pipe
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h111, 1'b1, 5'd13, 32'h222);
        winlog.delete();
        stall_cnt = 0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 5'd14, 32'h333, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check_eq("t3_order0", winlog[0], WB_SRC_MEM);
        check_eq("t3_order1", winlog[1], WB_SRC_MULDIV);
        check_eq("t3_order2", winlog[2], WB_SRC_PIPE);
        check_eq("t3_stalls", stall_cnt, 2);
        idle_step();

        // continuous mem stream starves the pipe until the override
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 32'h1000, 1'b0, 5'd0, 32'd0);
        mem_seq  = 1;
        grant_at = -1;
        for (int i = 0; i < 8; i++) begin
            step(grant_at < 0, 1'b1, 5'd20, 32'h5555, 1'b1, 5'(mem_seq % 31 + 1), 32'h1000 + mem_seq,
                 1'b0, 5'd0, 32'd0);
            if (last_pipe_gnt && grant_at < 0) begin
                grant_at = i;
                check_eq("t4_mem_rdy_low", last_mem_acc, 1'b0);
            end
            if (last_mem_acc) mem_seq++;
        end
        check_eq("t4_grant_cycle", grant_at, SM);
        for (int i = 0; i < 3; i++) idle_step();

        // write to x0 consumed silently; no-write pipe result never stalls
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF);
        step(1'b1, 1'b0, 5'd6, 32'h77, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        idle_step();
        check_eq("t5_x0_we", wb_if.reg_we_o, 1'b0);
        idle_step();

        // reset with both buffers full drops them
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd21, 32'hA1, 1'b1, 5'd22, 32'hA2);
        do_reset("rst1");
        for (int i = 0; i < 3; i++) idle_step();

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset("rstr");
            end else begin
                step($urandom_range(0, 3) != 0, $urandom_range(0, 5) != 0,
                     5'($urandom_range(0, 31)), 32'($urandom),
                     $urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)), 32'($urandom),
                     $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)), 32'($urandom));
            end
        end
        for (int i = 0; i < 4; i++) idle_step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
